tdm_mux4: RTL

- Four-channel time-division multiplexer/serializer; the transmit-side counterpart of the team's 1-to-4 demux.
- Takes a snapshot of four parallel channel words.
- Sends them one slot at a time on a single output bus.
- Drives the slot select alongside the data so a downstream demux can route each word back to its own channel.
- Sits between parallel source logic and a shared serial/time-shared link.

---
 rtl/tdm_mux4_if.sv | 24 ++
 rtl/tdm_mux4.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/tdm_mux4_if.sv
// tdm_mux4_if: bundle between a parallel source and the 4-channel TDM serializer.
// The source side (master) drives en and the parallel channel words; the serializer
// side (slave) drives the time-shared word, slot index and the frame status flags.
interface tdm_mux4_if #(
    parameter int WIDTH = 1
);
    logic               en;
    logic [4*WIDTH-1:0] in;
    logic [WIDTH-1:0]   out;
    logic [1:0]         s;
    logic               frame_start;
    logic               busy;
    logic               par_slot;

    modport master (
        output en, in,
        input  out, s, frame_start, busy, par_slot
    );

    modport slave (
        input  en, in,
        output out, s, frame_start, busy, par_slot
    );
endinterface

// File: rtl/tdm_mux4.sv
// tdm_mux4: four-channel time-division multiplexer / serializer.
// Snapshots four channel words at each frame boundary and sends them one slot at a
// time, each slot held for HOLD cycles, with the slot index on s for a downstream demux.
// Optional feature macro: TDM_PARITY_EN -- adds a fifth slot carrying ch0^ch1^ch2^ch3
// with s held at 3 and par_slot high. Without it the frame is four slots and
// par_slot is tied low.
module tdm_mux4 #(
    parameter int WIDTH = 1,
    parameter int HOLD  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    tdm_mux4_if.slave  bus
);
    localparam int            CW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_reg, state_next;
    logic [CW-1:0]      hold_reg, hold_next;
    logic [1:0]         s_reg, s_next;
    logic [4*WIDTH-1:0] snap_reg, snap_next;
    logic [WIDTH-1:0]   out_reg, out_next;
    logic               fs_reg, fs_next;
    logic               busy_reg, busy_next;

    logic [WIDTH-1:0]   ch [4];
    logic [1:0]         s_inc;
    logic               slot_end;
    logic               frame_end;
    logic               load;
    logic               stop;

    // Split the snapshot into per-channel words so slots can index them by s.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ch
            assign ch[gi] = snap_reg[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign s_inc    = s_reg + 2'd1;
    assign slot_end = (hold_reg == HOLD_LAST);

`ifdef TDM_PARITY_EN
    logic             par_reg, par_next;
    logic [WIDTH-1:0] par_word;

    assign par_word  = ch[0] ^ ch[1] ^ ch[2] ^ ch[3];
    // The frame only closes once the parity slot has been held for HOLD cycles.
    assign frame_end = slot_end && par_reg;
    assign bus.par_slot = par_reg;
`else
    assign frame_end = slot_end && (s_reg == 2'd3);
    assign bus.par_slot = 1'b0;
`endif

    // A new frame starts from IDLE or directly at the boundary of the previous one.
    assign load = bus.en && ((state_reg == IDLE) || frame_end);
    assign stop = (state_reg == RUN) && frame_end && !bus.en;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: en is only looked at in IDLE and on the last cycle of a frame.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (bus.en) state_next = RUN;
            RUN:     if (frame_end && !bus.en) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output/datapath next values: snapshot, slot sequencing and the registered word.
    always_comb begin
        hold_next = hold_reg;
        s_next    = s_reg;
        snap_next = snap_reg;
        out_next  = out_reg;
        fs_next   = 1'b0;
        busy_next = busy_reg;
`ifdef TDM_PARITY_EN
        par_next  = par_reg;
`endif
        if (load) begin
            snap_next = bus.in;
            s_next    = 2'd0;
            out_next  = bus.in[WIDTH-1:0];
            fs_next   = 1'b1;
            busy_next = 1'b1;
            hold_next = '0;
`ifdef TDM_PARITY_EN
            par_next  = 1'b0;
`endif
        end else if ((state_reg == IDLE) || stop) begin
            s_next    = 2'd0;
            out_next  = '0;
            busy_next = 1'b0;
            hold_next = '0;
`ifdef TDM_PARITY_EN
            par_next  = 1'b0;
`endif
        end else if (slot_end) begin
            hold_next = '0;
`ifdef TDM_PARITY_EN
            if (s_reg == 2'd3) begin
                // Parity slot keeps s at 3 so the demux index stays in range.
                par_next = 1'b1;
                out_next = par_word;
            end else begin
                s_next   = s_inc;
                out_next = ch[s_inc];
            end
`else
            s_next   = s_inc;
            out_next = ch[s_inc];
`endif
        end else begin
            hold_next = hold_reg + CW'(1);
        end
    end

    // Datapath registers, all cleared immediately by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_reg <= '0;
            s_reg    <= 2'd0;
            snap_reg <= '0;
            out_reg  <= '0;
            fs_reg   <= 1'b0;
            busy_reg <= 1'b0;
`ifdef TDM_PARITY_EN
            par_reg  <= 1'b0;
`endif
        end else begin
            hold_reg <= hold_next;
            s_reg    <= s_next;
            snap_reg <= snap_next;
            out_reg  <= out_next;
            fs_reg   <= fs_next;
            busy_reg <= busy_next;
`ifdef TDM_PARITY_EN
            par_reg  <= par_next;
`endif
        end
    end

    assign bus.out         = out_reg;
    assign bus.s           = s_reg;
    assign bus.frame_start = fs_reg;
    assign bus.busy        = busy_reg;
endmodule
